mau_action_seq: RTL
===================

// Module: mau_action_seq
// PURPOSE
//  Per-packet action sequencer for the MAU ALU. It accepts one PHV plus an action-list
//  descriptor (base, count) after the match stage. It fetches each action entry from the
//  Action SRAM, issues it to mau_alu and loops the ALU result back for the next action.
//  It emits the final PHV/meta with valid/ready. Sits between match lookup and the next
//  MAU stage; mau_alu is instantiated beside it in mau_stage.
// PARAMETERS
//  ADDR_W       10  Action SRAM address width (entries)
//  MAX_ACTIONS   8  max actions per packet; larger in_act_cnt is clamped to this value
//  CNT_W         4  width of in_act_cnt (must hold MAX_ACTIONS)
// PORTS
//  clk               in   1          core clock
//  rst               in   1          async active-high reset
//  in_valid          in   1          packet+descriptor valid
//  in_ready          out  1          seq can accept (state==IDLE)
//  in_phv            in   PHV_BITS   input PHV
//  in_meta           in   phv_meta_t input meta
//  in_act_base       in   ADDR_W     first action entry address
//  in_act_cnt        in   CNT_W      number of actions (0 = passthrough)
//  sram_rd_en        out  1          Action SRAM read strobe
//  sram_rd_addr      out  ADDR_W     read address
//  sram_rd_data      in   128        {action_id[127:112], action_params[111:0]}, 1-cycle latency
//  alu_phv           out  PHV_BITS   working PHV to ALU
//  alu_meta          out  phv_meta_t working meta to ALU
//  alu_valid_in      out  1          ALU valid_in
//  alu_action_id     out  16         ALU action_id
//  alu_action_params out  112        ALU action_params
//  alu_action_valid  out  1          ALU action_valid
//  alu_phv_out       in   PHV_BITS   ALU result, registered, 1 cycle after issue
//  alu_meta_out      in   phv_meta_t ALU meta result
//  alu_valid_out     in   1          ALU result valid
//  out_valid         out  1          result valid
//  out_ready         in   1          downstream accepts
//  out_phv           out  PHV_BITS   final PHV
//  out_meta          out  phv_meta_t final meta
//  busy              out  1          state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0 except in_ready=1. Reset mid-packet discards the
//    packet with no output.
//  - FSM: IDLE -> (accept, cnt>0) FETCH -> ISSUE -> WAIT -> FETCH (more) | OUT (done);
//    IDLE -> (accept, cnt==0) OUT; OUT -> IDLE on out_valid&&out_ready.
//  - Accept = in_valid&&in_ready. Latch phv/meta into the working regs.
//    Latch base; latch cnt clamped to MAX_ACTIONS; clear idx.
//  - FETCH: sram_rd_en=1, sram_rd_addr=base+idx (mod 2^ADDR_W, wraps).
//  - ISSUE: alu_valid_in=alu_action_valid=1; id/params from sram_rd_data; alu_phv/meta = working regs.
//  - WAIT: capture alu_phv_out/alu_meta_out into working regs; idx++. alu_valid_out must be 1 here.
//  - Latency: accept cycle C0 -> out_valid first high at C0+1+3*N; 3 cycles per action.
//  - OUT: out_valid=1; out_phv/meta stable until handshake; in_ready=0 outside IDLE (one packet in flight).
//  - alu_* outputs are 0 outside ISSUE; sram_rd_en is 0 outside FETCH.
// CONFIGURATION
//  MAU_SEQ_EARLY_DROP_EN defined: in WAIT, if captured meta.drop==1, go to OUT and skip the
//    remaining actions.
//  Not defined: all N actions always execute regardless of drop.
// STRUCTURE
//  rv_p4_pkg: act_entry_t {logic [15:0] action_id; logic [111:0] params;}; mau_seq_state_e
//    {IDLE,FETCH,ISSUE,WAIT,OUT}; ACT_ENTRY_BITS=128.
//  No sub-module; single FSM + idx counter + working PHV/meta registers.
// TESTING
//  1 cnt=0, base=5 -> no sram_rd_en; out_phv==in_phv, out_meta==in_meta; out_valid at C0+1.
//  2 cnt=2, base=0x3FF, entries SET 16b imm 0x1234 @off 4, then ADD 16b imm 1 @off 4
//    -> reads at 0x3FF then 0x000; out PHV bytes 4-5 = 0x1235; out_valid at C0+7.
//  3 cnt=12 (MAX_ACTIONS=8) -> exactly 8 sram reads, out_valid at C0+25.
//  4 out_ready held 0 for 10 cycles in OUT -> out_valid, out_phv, out_meta stable;
//    in_ready=0 with in_valid=1 throughout.
//  5 cnt=3, action0=DROP -> with MAU_SEQ_EARLY_DROP_EN: 1 read, out_valid C0+4, meta.drop=1;
//    without: 3 reads, out_valid C0+10.
//  6 assert rst in ISSUE of action 1 of 3 -> next cycle all outputs 0, in_ready=1, no out_valid
//    ever for that packet.

Source files
------------

// File: rtl/rv_p4_pkg.sv
// Shared types for the MAU action sequencer: PHV meta, action entry, FSM states.
// Optional early drop is enabled in mau_action_seq by MAU_SEQ_EARLY_DROP_EN.
package rv_p4_pkg;

  localparam int PHV_BITS       = 128;
  localparam int ACT_ENTRY_BITS = 128;
  localparam int ACT_ID_BITS    = 16;
  localparam int ACT_PRM_BITS   = 112;

  typedef struct packed {
    logic       drop;
    logic [6:0] egress_port;
    logic [7:0] flow_tag;
  } phv_meta_t;

  typedef struct packed {
    logic [ACT_ID_BITS-1:0]  action_id;
    logic [ACT_PRM_BITS-1:0] params;
  } act_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    OUT
  } mau_seq_state_e;

endpackage

// File: rtl/mau_action_seq.sv
// Per-packet MAU action sequencer: fetch entry, issue to ALU, loop result back.
// MAU_SEQ_EARLY_DROP_EN: stop the action list once the ALU marks the packet dropped.
module mau_action_seq
  import rv_p4_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int MAX_ACTIONS = 8,
  parameter int CNT_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PHV_BITS-1:0]     in_phv,
  input  phv_meta_t               in_meta,
  input  logic [ADDR_W-1:0]       in_act_base,
  input  logic [CNT_W-1:0]        in_act_cnt,
  output logic                    sram_rd_en,
  output logic [ADDR_W-1:0]       sram_rd_addr,
  input  logic [ACT_ENTRY_BITS-1:0] sram_rd_data,
  output logic [PHV_BITS-1:0]     alu_phv,
  output phv_meta_t               alu_meta,
  output logic                    alu_valid_in,
  output logic [ACT_ID_BITS-1:0]  alu_action_id,
  output logic [ACT_PRM_BITS-1:0] alu_action_params,
  output logic                    alu_action_valid,
  input  logic [PHV_BITS-1:0]     alu_phv_out,
  input  phv_meta_t               alu_meta_out,
  input  logic                    alu_valid_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PHV_BITS-1:0]     out_phv,
  output phv_meta_t               out_meta,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ACTIONS);

  mau_seq_state_e r_state;
  mau_seq_state_e w_state_nxt;

  logic [PHV_BITS-1:0] r_phv;
  phv_meta_t           r_meta;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_idx;

  logic             w_accept;
  logic             w_last;
  logic             w_drop;
  logic [CNT_W-1:0] w_idx_inc;
  logic [CNT_W-1:0] w_cnt_clamp;
  act_entry_t       w_entry;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_idx_inc   = r_idx + CNT_W'(1);
  assign w_last      = (w_idx_inc >= r_cnt);
  assign w_entry     = act_entry_t'(sram_rd_data);
  assign w_cnt_clamp = (in_act_cnt > MAX_CNT) ? MAX_CNT : in_act_cnt;

`ifdef MAU_SEQ_EARLY_DROP_EN
  assign w_drop = alu_meta_out.drop;
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phv   <= '0;
      r_meta  <= '0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_phv  <= in_phv;
        r_meta <= in_meta;
        r_base <= in_act_base;
        r_cnt  <= w_cnt_clamp;
        r_idx  <= '0;
      end else if (r_state == WAIT && alu_valid_out) begin
        r_phv  <= alu_phv_out;
        r_meta <= alu_meta_out;
        r_idx  <= w_idx_inc;
      end
    end
  end

  // A late ALU result holds the sequencer in WAIT rather than capturing junk.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (in_act_cnt == '0) ? OUT : FETCH;
        end
      end
      FETCH: w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (alu_valid_out) begin
          w_state_nxt = (w_last || w_drop) ? OUT : FETCH;
        end
      end
      OUT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready          = (r_state == IDLE);
    busy              = (r_state != IDLE);
    sram_rd_en        = 1'b0;
    sram_rd_addr      = '0;
    alu_phv           = '0;
    alu_meta          = '0;
    alu_valid_in      = 1'b0;
    alu_action_id     = '0;
    alu_action_params = '0;
    alu_action_valid  = 1'b0;
    out_valid         = 1'b0;
    out_phv           = '0;
    out_meta          = '0;
    unique case (r_state)
      FETCH: begin
        sram_rd_en   = 1'b1;
        sram_rd_addr = r_base + ADDR_W'(r_idx);
      end
      ISSUE: begin
        alu_valid_in      = 1'b1;
        alu_action_valid  = 1'b1;
        alu_action_id     = w_entry.action_id;
        alu_action_params = w_entry.params;
        alu_phv           = r_phv;
        alu_meta          = r_meta;
      end
      OUT: begin
        out_valid = 1'b1;
        out_phv   = r_phv;
        out_meta  = r_meta;
      end
      default: ;
    endcase
  end

endmodule
